// File: rtl/ram_arbiter.sv
// Dual-core RAM arbiter: shares one single-port RAM between two cores, each
// with an instruction port and a data port. Round-robin between cores, data
// write > data read > instruction read inside a core. A grant is held until
// the RAM answers ACCESS or ERROR, or until the granted request line drops.
module ram_arbiter #(
    parameter int CPUS   = 2,   // only 2 is supported
    parameter int WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS*WORD_W-1:0] iaddr,
    input  logic [CPUS*WORD_W-1:0] daddr,
    input  logic [CPUS*WORD_W-1:0] dstore,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS*WORD_W-1:0] iload,
    output logic [CPUS*WORD_W-1:0] dload,
    input  logic [1:0]             ramstate,
    input  logic [WORD_W-1:0]      ramload,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    output logic                   ramREN,
    output logic                   ramWEN
);

    // RAM status encoding (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic { IDLE, GRANT } state_t;
    typedef enum logic [1:0] { IW = 2'd0, DR = 2'd1, IR = 2'd2 } gtype_t;

    state_t      r_state, w_state_nxt;
    logic        r_gcpu,  w_gcpu_nxt;
    gtype_t      r_gtype, w_gtype_nxt;
    logic        r_last,  w_last_nxt;

    logic [CPUS-1:0]   w_pend;
    logic              w_sel;
    gtype_t            w_sel_type;
    logic              w_line;

    logic [WORD_W-1:0] w_iaddr  [CPUS];
    logic [WORD_W-1:0] w_daddr  [CPUS];
    logic [WORD_W-1:0] w_dstore [CPUS];
    logic [WORD_W-1:0] w_iload  [CPUS];
    logic [WORD_W-1:0] w_dload  [CPUS];

    // Unpack the per-core buses into arrays and pack the load arrays back out
    for (genvar g = 0; g < CPUS; g++) begin : g_core
        assign w_iaddr[g]                  = iaddr[g*WORD_W +: WORD_W];
        assign w_daddr[g]                  = daddr[g*WORD_W +: WORD_W];
        assign w_dstore[g]                 = dstore[g*WORD_W +: WORD_W];
        assign iload[g*WORD_W +: WORD_W]   = w_iload[g];
        assign dload[g*WORD_W +: WORD_W]   = w_dload[g];
    end

    assign w_pend = iREN | dREN | dWEN;

    // Pick the core to grant (the one not served last on a tie) and its request type
    always_comb begin
        w_sel = w_pend[1];
        if (&w_pend) begin
            w_sel = ~r_last;
        end
        w_sel_type = IR;
        if (dWEN[w_sel]) begin
            w_sel_type = IW;
        end else if (dREN[w_sel]) begin
            w_sel_type = DR;
        end
    end

    // Live level of the request line that owns the current grant
    always_comb begin
        case (r_gtype)
            IW:      w_line = dWEN[r_gcpu];
            DR:      w_line = dREN[r_gcpu];
            default: w_line = iREN[r_gcpu];
        endcase
    end

    // Next-state logic: a grant ends on completion, RAM error or a dropped request
    always_comb begin
        w_state_nxt = r_state;
        w_gcpu_nxt  = r_gcpu;
        w_gtype_nxt = r_gtype;
        w_last_nxt  = r_last;
        if (r_state == IDLE) begin
            if (|w_pend) begin
                w_state_nxt = GRANT;
                w_gcpu_nxt  = w_sel;
                w_gtype_nxt = w_sel_type;
            end
        end else begin
            if (!w_line) begin
                w_state_nxt = IDLE;
            end else if (ramstate == RAM_ACCESS) begin
                w_state_nxt = IDLE;
                w_last_nxt  = r_gcpu;
            end else if (ramstate == RAM_ERROR) begin
                w_state_nxt = IDLE;
            end
        end
    end

    // RAM drive and core handshake; only the completing request sees its wait drop
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        for (int c = 0; c < CPUS; c++) begin
            w_iload[c] = '0;
            w_dload[c] = '0;
        end
        if (r_state == GRANT) begin
            case (r_gtype)
                IW: begin
                    ramWEN   = 1'b1;
                    ramaddr  = w_daddr[r_gcpu];
                    ramstore = w_dstore[r_gcpu];
                end
                DR: begin
                    ramREN  = 1'b1;
                    ramaddr = w_daddr[r_gcpu];
                end
                default: begin
                    ramREN  = 1'b1;
                    ramaddr = w_iaddr[r_gcpu];
                end
            endcase
            if (ramstate == RAM_ACCESS && w_line) begin
                case (r_gtype)
                    IW: begin
                        dwait[r_gcpu] = 1'b0;
                    end
                    DR: begin
                        dwait[r_gcpu]   = 1'b0;
                        w_dload[r_gcpu] = ramload;
                    end
                    default: begin
                        iwait[r_gcpu]   = 1'b0;
                        w_iload[r_gcpu] = ramload;
                    end
                endcase
            end
        end
    end

    // State registers; last resets to 1 so core 0 wins the first tie
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_gcpu  <= 1'b0;
            r_gtype <= IR;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gcpu  <= w_gcpu_nxt;
            r_gtype <= w_gtype_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Dual-core RAM arbiter. Shares one single-port RAM between two CPUs, each with an instruction port and a data port.
- Sits between the per-core cache_control_if request lines and the RAM model, in place of the single-core memory controller path.
- Holds a grant until the RAM reports ACCESS, so the address and data seen by the RAM stay stable for the whole RAM latency.
- Round-robin arbitration across cores; fixed data-over-instruction priority within a core.

Parameters:
- CPUS, 2, number of requesting cores. The design supports only 2.
- WORD_W, 32, data and address width.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  CPUS  instruction read request, per core
- dREN  in  CPUS  data read request, per core
- dWEN  in  CPUS  data write request, per core
- iaddr  in  CPUS*WORD_W  instruction address; core n occupies bits [n*WORD_W +: WORD_W]
- daddr  in  CPUS*WORD_W  data address, packed the same way
- dstore  in  CPUS*WORD_W  write data, packed the same way
- iwait  out  CPUS  instruction wait (1 = stall)
- dwait  out  CPUS  data wait (1 = stall)
- iload  out  CPUS*WORD_W  instruction read data
- dload  out  CPUS*WORD_W  data read data
- ramstate  in  2  RAM status, ramstate_t: FREE, BUSY, ACCESS, ERROR
- ramload  in  WORD_W  RAM read data
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable

Behaviour:
- Registers:
  - state: IDLE or GRANT.
  - gcpu: granted core, 1 bit.
  - gtype: granted request type: IW (data write), DR (data read), IR (instruction read).
  - last: core served most recently, 1 bit.
- Reset (asynchronous, nRST=0): state=IDLE, gcpu=0, gtype=IR, last=1, so core 0 wins the first tie.
  - Outputs during reset and in IDLE: all iwait/dwait=1, iload/dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Pending request: core n has one if iREN[n], dREN[n] or dWEN[n] is set.
- Type for core n: dWEN > dREN > iREN. If dWEN and dREN are both set, the request is treated as a write.
- Core selection in IDLE:
  - If both cores are pending, pick the core != last.
  - Otherwise pick the single pending core.
  - If none is pending, stay in IDLE.
- IDLE with a request: register gcpu/gtype, go to GRANT at the next edge. IDLE lasts exactly one cycle between back-to-back transactions.
- GRANT outputs (combinational from gcpu, gtype and live inputs):
  - IW: ramWEN=1, ramaddr=daddr[gcpu], ramstore=dstore[gcpu].
  - DR: ramREN=1, ramaddr=daddr[gcpu].
  - IR: ramREN=1, ramaddr=iaddr[gcpu].
  - Outputs not listed for a type stay 0.
- Completion, when state=GRANT, ramstate==ACCESS and the granted request line is still high:
  - The matching wait bit (dwait[gcpu] for IW/DR, iwait[gcpu] for IR) goes to 0 for that one cycle only.
  - For DR, dload[gcpu]=ramload in that cycle. For IR, iload[gcpu]=ramload in that cycle. All other load fields are 0.
  - Next edge: last<=gcpu, state<=IDLE.
- Abort, when state=GRANT and the granted request line drops (e.g. a dWEN grant whose dWEN deasserts):
  - Next edge: IDLE. last is unchanged. No wait bit is lowered.
  - A type change inside the same core, such as dREN falling while dWEN rises, is handled as an abort and then re-arbitrated.
- ERROR: when state=GRANT and ramstate==ERROR, go to IDLE at the next edge. The wait bit stays 1 and last is unchanged; the requester is re-arbitrated and retries.
- FREE or BUSY while in GRANT: hold the grant, keep outputs stable, keep waits at 1.
- Only one wait bit in the whole block is ever 0 in any cycle.
- Minimum latency from request to wait=0 is 2 cycles: one IDLE cycle plus one GRANT cycle with ACCESS.
- Reset asserted mid-GRANT: RAM enables drop immediately, state returns to IDLE, and no completion is signalled.

Test Plan:
- Reset, then iREN[0]=1, iaddr0=0x40, ramstate=ACCESS on the first GRANT cycle -> ramREN=1, ramaddr=0x40 in that cycle; iwait[0]=0 for exactly 1 cycle; iload0 = ramload (0xDEADBEEF); iwait[1] and both dwait stay 1.
- dREN[0] and dREN[1] asserted together and held, ramstate=ACCESS on the 3rd GRANT cycle each time -> service order core0, core1, core0, core1; one IDLE cycle between grants; dwait never 0 for both cores in the same cycle.
- Core 1 asserts dWEN=1 (daddr1=0x80, dstore1=0x1234) and iREN=1 together -> write served first with ramWEN=1, ramstore=0x1234; instruction read follows in the next grant.
- Core 0 granted DR with ramstate=BUSY, then dREN[0] drops -> IDLE next edge; dwait[0] never 0; a pending core 1 request is granted, and last is still 1 so core 0 wins the next tie.
- Granted IR sees ramstate=ERROR -> IDLE; iwait stays 1; the request is re-granted; completes when ACCESS is returned.
- nRST pulsed low during GRANT with ramstate=BUSY -> ramREN and ramWEN go to 0 asynchronously; all waits are 1; after release, core 0 wins the first tie.
